// File: rtl/riscv_obi_rr_arbiter.sv
// riscv_obi_rr_arbiter: shares one OBI slave port between two OBI masters.
// The address phase is arbitrated round-robin. A request that is not yet granted
// locks its master. An in-order ID FIFO routes each response back to its issuer.
// Define OBI_ARB_FIXED_PRIO_EN to make unlocked ties always go to m0.
module riscv_obi_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 m0_req_i,
  input  logic [ADDR_WIDTH-1:0]                m0_addr_i,
  input  logic                                 m0_we_i,
  input  logic [DATA_WIDTH/8-1:0]              m0_be_i,
  input  logic [DATA_WIDTH-1:0]                m0_wdata_i,
  output logic                                 m0_gnt_o,
  output logic                                 m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]                m0_rdata_o,
  input  logic                                 m1_req_i,
  input  logic [ADDR_WIDTH-1:0]                m1_addr_i,
  input  logic                                 m1_we_i,
  input  logic [DATA_WIDTH/8-1:0]              m1_be_i,
  input  logic [DATA_WIDTH-1:0]                m1_wdata_i,
  output logic                                 m1_gnt_o,
  output logic                                 m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]                m1_rdata_o,
  output logic                                 s_req_o,
  output logic [ADDR_WIDTH-1:0]                s_addr_o,
  output logic                                 s_we_o,
  output logic [DATA_WIDTH/8-1:0]              s_be_o,
  output logic [DATA_WIDTH-1:0]                s_wdata_o,
  input  logic                                 s_gnt_i,
  input  logic                                 s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
  output logic                                 err_o
);

  localparam int unsigned IdxW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned PtrW = IdxW + 1;

  // One ID bit per slot: 0 = m0, 1 = m1.
  logic [MAX_OUTSTANDING-1:0] r_id_fifo;
  logic [PtrW-1:0]            r_wptr;
  logic [PtrW-1:0]            r_rptr;
  logic                       r_lock;
  logic                       r_lock_owner;
  logic                       r_err;
`ifndef OBI_ARB_FIXED_PRIO_EN
  logic                       r_last_grant;
`endif

  logic w_sel;
  logic w_sel_req;
  logic w_empty;
  logic w_full;
  logic w_hs;
  logic w_pop;
  logic w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PtrW-1] != r_rptr[PtrW-1]) &&
                   (r_wptr[IdxW-1:0] == r_rptr[IdxW-1:0]);

  // Pick the master that owns the address phase this cycle.
  always_comb begin
    w_sel = 1'b0;
    if (r_lock) begin
      w_sel = r_lock_owner;
    end else if (m0_req_i && !m1_req_i) begin
      w_sel = 1'b0;
    end else if (m1_req_i && !m0_req_i) begin
      w_sel = 1'b1;
    end else if (m0_req_i && m1_req_i) begin
`ifdef OBI_ARB_FIXED_PRIO_EN
      w_sel = 1'b0;
`else
      w_sel = ~r_last_grant;
`endif
    end
  end

  assign w_sel_req = w_sel ? m1_req_i : m0_req_i;
  assign s_req_o   = w_sel_req && !w_full;
  assign w_hs      = s_req_o && s_gnt_i;
  assign m0_gnt_o  = w_hs && !w_sel;
  assign m1_gnt_o  = w_hs && w_sel;

  // Address-phase mux; fields read as zero when no request goes out.
  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (s_req_o) begin
      s_addr_o  = w_sel ? m1_addr_i  : m0_addr_i;
      s_we_o    = w_sel ? m1_we_i    : m0_we_i;
      s_be_o    = w_sel ? m1_be_i    : m0_be_i;
      s_wdata_o = w_sel ? m1_wdata_i : m0_wdata_i;
    end
  end

  assign w_pop  = s_rvalid_i && !w_empty;
  assign w_head = r_id_fifo[r_rptr[IdxW-1:0]];

  assign m0_rvalid_o   = w_pop && !w_head;
  assign m1_rvalid_o   = w_pop && w_head;
  assign m0_rdata_o    = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o    = m1_rvalid_o ? s_rdata_i : '0;
  assign outstanding_o = r_wptr - r_rptr;
  assign err_o         = r_err;

  // ID FIFO: push the granted master, pop on every slave response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id_fifo <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else begin
      if (w_hs) begin
        r_id_fifo[r_wptr[IdxW-1:0]] <= w_sel;
        r_wptr                      <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Hold the selection while a request waits for grant so the address phase stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock       <= 1'b0;
      r_lock_owner <= 1'b0;
    end else if (w_hs) begin
      r_lock <= 1'b0;
    end else if (s_req_o) begin
      r_lock       <= 1'b1;
      r_lock_owner <= w_sel;
    end
  end

`ifndef OBI_ARB_FIXED_PRIO_EN
  // Remember the last winner so the next tie goes to the other master.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_grant <= 1'b1;
    end else if (w_hs) begin
      r_last_grant <= w_sel;
    end
  end
`endif

  // A response with nothing outstanding is a protocol error; sticky until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (s_rvalid_i && w_empty) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_obi_rr_arbiter.sv
// Self-checking bench for riscv_obi_rr_arbiter: directed scenarios with literal
// expectations, then randomized OBI traffic against a queue-based reference model.
module tb_riscv_obi_rr_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          m0_req_i, m1_req_i, m0_we_i, m1_we_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW/8-1:0] m0_be_i, m1_be_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          s_req_o, s_we_o, s_gnt_i, s_rvalid_i;
  logic [AW-1:0] s_addr_o;
  logic [DW/8-1:0] s_be_o;
  logic [DW-1:0] s_wdata_o, s_rdata_i;
  logic [$clog2(MAX):0] outstanding_o;
  logic          err_o;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int q[$];
  bit last_g;
  bit lock_m;
  bit owner_m;
  bit err_m;
  // Per-cycle model decisions
  bit e_sel, e_sreq, e_hs;
  bit e_gnt[2];

  riscv_obi_rr_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    m0_req_i = 0; m0_addr_i = '0; m0_we_i = 0; m0_be_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_addr_i = '0; m1_we_i = 0; m1_be_i = '0; m1_wdata_i = '0;
    s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = '0;
  endtask

  // Compute what the outputs must be from the arbitration rules and compare.
  task automatic check_model();
    bit r0, r1, full, popv, head;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic [DW/8-1:0] eb;
    logic ewe;
    r0 = m0_req_i; r1 = m1_req_i;
    if (lock_m) e_sel = owner_m;
    else if (r0 && !r1) e_sel = 0;
    else if (r1 && !r0) e_sel = 1;
    else if (r0 && r1) begin
`ifdef OBI_ARB_FIXED_PRIO_EN
      e_sel = 0;
`else
      e_sel = !last_g;
`endif
    end else e_sel = 0;
    full = (q.size() >= MAX);
    e_sreq = (e_sel ? r1 : r0) && !full;
    e_hs = e_sreq && s_gnt_i;
    e_gnt[0] = e_hs && !e_sel;
    e_gnt[1] = e_hs && e_sel;
    ea  = !e_sreq ? '0 : (e_sel ? m1_addr_i  : m0_addr_i);
    ewe = !e_sreq ? 1'b0 : (e_sel ? m1_we_i : m0_we_i);
    eb  = !e_sreq ? '0 : (e_sel ? m1_be_i    : m0_be_i);
    ew  = !e_sreq ? '0 : (e_sel ? m1_wdata_i : m0_wdata_i);
    popv = s_rvalid_i && (q.size() > 0);
    head = popv ? q[0][0] : 1'b0;
    chk("s_req", s_req_o, e_sreq);
    chk("s_addr", s_addr_o, ea);
    chk("s_we", s_we_o, ewe);
    chk("s_be", s_be_o, eb);
    chk("s_wdata", s_wdata_o, ew);
    chk("m0_gnt", m0_gnt_o, e_gnt[0]);
    chk("m1_gnt", m1_gnt_o, e_gnt[1]);
    chk("m0_rvalid", m0_rvalid_o, popv && !head);
    chk("m1_rvalid", m1_rvalid_o, popv && head);
    chk("m0_rdata", m0_rdata_o, (popv && !head) ? s_rdata_i : '0);
    chk("m1_rdata", m1_rdata_o, (popv && head) ? s_rdata_i : '0);
    chk("outstanding", outstanding_o, q.size());
    chk("err", err_o, err_m);
  endtask

  task automatic update_model();
    if (s_rvalid_i) begin
      if (q.size() > 0) void'(q.pop_front());
      else err_m = 1;
    end
    if (e_hs) begin
      q.push_back(int'(e_sel));
      last_g = e_sel;
      lock_m = 0;
    end else if (e_sreq) begin
      lock_m  = 1;
      owner_m = e_sel;
    end
  endtask

  task automatic settle();
    #1;
    check_model();
  endtask

  task automatic finish_cycle();
    update_model();
    @(negedge clk_i);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    idle_inputs();
    rst_ni = 0;
    q.delete(); last_g = 1; lock_m = 0; owner_m = 0; err_m = 0;
    #1;
    check_model();
    chk("reset_outstanding", outstanding_o, 0);
    chk("reset_err", err_o, 0);
    chk("reset_s_req", s_req_o, 0);
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  bit hold[2];

  initial begin
    idle_inputs();
    @(negedge clk_i);

    // 1: single m0 read, response two cycles later
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h1000_0040; s_gnt_i = 1;
    settle();
    chk("t1_gnt", m0_gnt_o, 1);
    chk("t1_addr", s_addr_o, 32'h1000_0040);
    finish_cycle();
    idle_inputs();
    settle(); finish_cycle();
    s_rvalid_i = 1; s_rdata_i = 32'hDEADBEEF;
    settle();
    chk("t1_rvalid", m0_rvalid_o, 1);
    chk("t1_rdata", m0_rdata_o, 32'hDEADBEEF);
    chk("t1_m1_rvalid", m1_rvalid_o, 0);
    finish_cycle();
    idle_inputs();

    // 2: both masters request continuously, grants alternate
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1;
      m0_addr_i = 32'h100 + i; m1_addr_i = 32'h200 + i;
      settle();
`ifdef OBI_ARB_FIXED_PRIO_EN
      chk("t2_gnt0", m0_gnt_o, 1);
`else
      chk("t2_gnt1", m1_gnt_o, (i % 2) == 1);
      chk("t2_gnt0", m0_gnt_o, (i % 2) == 0);
`endif
      finish_cycle();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      s_rvalid_i = 1; s_rdata_i = 32'hA0 + i;
      settle();
`ifndef OBI_ARB_FIXED_PRIO_EN
      chk("t2_rv1", m1_rvalid_o, (i % 2) == 1);
`endif
      finish_cycle();
    end
    idle_inputs();

    // 3: m1 stalls without grant; m0 arriving later must not steal the slave
    do_reset();
    m1_req_i = 1; m1_addr_i = 32'hB000_0004;
    settle(); finish_cycle();
    for (int i = 1; i < 3; i++) begin
      m0_req_i = 1; m0_addr_i = 32'hA000_0008;
      settle();
      chk("t3_addr_locked", s_addr_o, 32'hB000_0004);
      chk("t3_no_gnt0", m0_gnt_o, 0);
      finish_cycle();
    end
    s_gnt_i = 1;
    settle();
    chk("t3_gnt1", m1_gnt_o, 1);
    finish_cycle();
    m1_req_i = 0;
    settle();
    chk("t3_gnt0", m0_gnt_o, 1);
    chk("t3_addr0", s_addr_o, 32'hA000_0008);
    finish_cycle();
    idle_inputs();

    // 4: fill the ID FIFO, then free one slot
    do_reset();
    m0_req_i = 1; s_gnt_i = 1;
    for (int i = 0; i < MAX; i++) begin
      m0_addr_i = 32'h40 * i;
      settle(); finish_cycle();
    end
    settle();
    chk("t4_full_cnt", outstanding_o, MAX);
    chk("t4_full_req", s_req_o, 0);
    finish_cycle();
    s_rvalid_i = 1; s_rdata_i = 32'h1234;
    settle();
    chk("t4_pop_blocked", m0_gnt_o, 0);
    finish_cycle();
    s_rvalid_i = 0;
    settle();
    chk("t4_resume", m0_gnt_o, 1);
    chk("t4_cnt", outstanding_o, MAX - 1);
    finish_cycle();
    idle_inputs();

    // 5: response with nothing outstanding
    do_reset();
    s_rvalid_i = 1; s_rdata_i = 32'h5555;
    settle();
    chk("t5_rv0", m0_rvalid_o, 0);
    chk("t5_rv1", m1_rvalid_o, 0);
    finish_cycle();
    s_rvalid_i = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t5_err", err_o, 1);
      finish_cycle();
    end

    // 6: reset with transactions in flight
    do_reset();
    m0_req_i = 1; s_gnt_i = 1;
    for (int i = 0; i < 3; i++) begin
      settle(); finish_cycle();
    end
    settle();
    chk("t6_pre", outstanding_o, 3);
    do_reset();
    chk("t6_cnt", outstanding_o, 0);
    m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1;
    settle();
    chk("t6_tie_m0", m0_gnt_o, 1);
    finish_cycle();
    idle_inputs();

    // Randomized OBI-compliant traffic
    do_reset();
    hold[0] = 0; hold[1] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        hold[0] = 0; hold[1] = 0;
      end
      if (!hold[0]) begin
        m0_req_i = ($urandom_range(0, 99) < 60);
        m0_addr_i = $urandom; m0_we_i = $urandom_range(0, 1);
        m0_be_i = 4'($urandom); m0_wdata_i = $urandom;
      end
      if (!hold[1]) begin
        m1_req_i = ($urandom_range(0, 99) < 60);
        m1_addr_i = $urandom; m1_we_i = $urandom_range(0, 1);
        m1_be_i = 4'($urandom); m1_wdata_i = $urandom;
      end
      s_gnt_i = ($urandom_range(0, 99) < 70);
      if (q.size() > 0) s_rvalid_i = ($urandom_range(0, 99) < 40);
      else s_rvalid_i = ($urandom_range(0, 499) == 0);
      s_rdata_i = $urandom;
      settle();
      hold[0] = m0_req_i && !e_gnt[0];
      hold[1] = m1_req_i && !e_gnt[1];
      finish_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
